// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier: controller state encoding and
// the default iteration-counter width.
package mul_pkg;

  localparam int unsigned DefaultCntW = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadA = 3'd1,
    StLoadB = 3'd2,
    StCheck = 3'd3,
    StAdd   = 3'd4,
    StDone  = 3'd5
  } mul_state_e;

endpackage

// File: rtl/mul_iter_cnt.sv
// Saturating iteration counter with synchronous clear, count enable and a limit compare.
module mul_iter_cnt
  import mul_pkg::*;
#(
  parameter int unsigned CNT_W    = DefaultCntW,
  parameter int unsigned MAX_ITER = (2 ** CNT_W) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MaxVal = CNT_W'(MAX_ITER);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !at_max) begin
      // The controller never adds at the limit; the guard just keeps the count from wrapping.
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt    = cnt_q;
  assign at_max = (cnt_q == MaxVal);

endmodule

// File: rtl/mul_ctrl.sv
// Control FSM for the repeated-addition multiplier: loads A and B from the shared bus,
// clears P, then loops P += A / B -= 1 until B reaches zero or the iteration limit is hit.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned CNT_W    = DefaultCntW,
  parameter int unsigned MAX_ITER = (2 ** CNT_W) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_valid,
  input  logic             eqz,
  output logic             ld_a,
  output logic             ld_b,
  output logic             clr_p,
  output logic             ld_p,
  output logic             dec_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             err
);

  mul_state_e state_q, state_d;
  logic       err_q, err_d;
  logic       cnt_clr, cnt_en, at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    clr_p   = 1'b0;
    ld_p    = 1'b0;
    dec_b   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoadA;
          err_d   = 1'b0;
        end
      end
      StLoadA: begin
        busy = 1'b1;
        ld_a = op_valid;
        if (op_valid) state_d = StLoadB;
      end
      StLoadB: begin
        busy  = 1'b1;
        ld_b  = op_valid;
        clr_p = op_valid;
        if (op_valid) state_d = StCheck;
      end
      StCheck: begin
        busy = 1'b1;
        if (eqz) begin
          state_d = StDone;
        end else if (at_max) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StAdd;
        end
      end
      StAdd: begin
        busy    = 1'b1;
        ld_p    = 1'b1;
        dec_b   = 1'b1;
        state_d = StCheck;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign cnt_clr = (state_q == StIdle) && start;
  assign cnt_en  = (state_q == StAdd);

  mul_iter_cnt #(
    .CNT_W   (CNT_W),
    .MAX_ITER(MAX_ITER)
  ) u_iter_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (iter_cnt),
    .at_max(at_max)
  );

  assign err = err_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: two controllers (full width and CNT_W=2) wrapped in an A/B/P datapath
// model, with a scoreboard of expected results checked whenever done is presented.
module tb_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start_s = 1'b0, op_valid = 1'b0;
  logic [7:0]  bus = 8'd0;
  longint unsigned cyc = 0;
  int unsigned total = 0, bad = 0;

  // Lane 0: CNT_W=16
  logic        ld_a0, ld_b0, clr_p0, ld_p0, dec_b0, busy0, done0, err0, eqz0;
  logic [15:0] it0;
  logic [7:0]  a0 = 8'd0, b0 = 8'd0;
  logic [15:0] p0 = 16'd0;
  // Lane 1: CNT_W=2, MAX_ITER=3
  logic        ld_a1, ld_b1, clr_p1, ld_p1, dec_b1, busy1, done1, err1, eqz1;
  logic [1:0]  it1;
  logic [7:0]  a1 = 8'd0, b1 = 8'd0;
  logic [15:0] p1 = 16'd0;

  typedef struct {
    int unsigned     p;
    int unsigned     it;
    bit              er;
    longint unsigned dcyc;
    int unsigned     lp0;
  } exp_t;
  exp_t q0[$], q1[$];
  int unsigned lp_tot0 = 0, lp_tot1 = 0;

  mul_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_valid(op_valid), .eqz(eqz0),
    .ld_a(ld_a0), .ld_b(ld_b0), .clr_p(clr_p0), .ld_p(ld_p0), .dec_b(dec_b0),
    .busy(busy0), .done(done0), .iter_cnt(it0), .err(err0)
  );

  mul_ctrl #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .op_valid(op_valid), .eqz(eqz1),
    .ld_a(ld_a1), .ld_b(ld_b1), .clr_p(clr_p1), .ld_p(ld_p1), .dec_b(dec_b1),
    .busy(busy1), .done(done1), .iter_cnt(it1), .err(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath models
  assign eqz0 = (b0 == 8'd0);
  assign eqz1 = (b1 == 8'd0);
  always @(posedge clk) begin
    if (ld_a0) a0 <= bus;
    if (ld_b0) b0 <= bus;
    else if (dec_b0) b0 <= b0 - 8'd1;
    if (clr_p0) p0 <= 16'd0;
    else if (ld_p0) p0 <= p0 + {8'd0, a0};
    if (ld_a1) a1 <= bus;
    if (ld_b1) b1 <= bus;
    else if (dec_b1) b1 <= b1 - 8'd1;
    if (clr_p1) p1 <= 16'd0;
    else if (ld_p1) p1 <= p1 + {8'd0, a1};
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    exp_t e;
    if (ld_p0) lp_tot0 <= lp_tot0 + 1;
    if (ld_p1) lp_tot1 <= lp_tot1 + 1;
    if (ld_a0 || ld_b0 || clr_p0 || ld_a1 || ld_b1 || clr_p1)
      chk("load_needs_op_valid", 64'(op_valid), 64'd1);
    if (done0) begin
      if (q0.size() == 0) chk("spurious_done0", 64'd1, 64'd0);
      else begin
        e = q0.pop_front();
        chk("p0", 64'(p0), 64'(e.p));
        chk("iter0", 64'(it0), 64'(e.it));
        chk("err0", 64'(err0), 64'(e.er));
        chk("done_cycle0", cyc, e.dcyc);
        chk("ld_p_count0", 64'(lp_tot0 - e.lp0), 64'(e.it));
        chk("busy_at_done0", 64'(busy0), 64'd0);
      end
    end
    if (done1) begin
      if (q1.size() == 0) chk("spurious_done1", 64'd1, 64'd0);
      else begin
        e = q1.pop_front();
        chk("p1", 64'(p1), 64'(e.p));
        chk("iter1", 64'(it1), 64'(e.it));
        chk("err1", 64'(err1), 64'(e.er));
        chk("done_cycle1", cyc, e.dcyc);
        chk("ld_p_count1", 64'(lp_tot1 - e.lp0), 64'(e.it));
      end
    end
  end

  // Called just after the edge that sampled start; pushes the reference result and feeds
  // operands with the requested number of stall cycles before each.
  task automatic feed(input bit lane, input int unsigned a, input int unsigned b,
                      input int unsigned sa, input int unsigned sb);
    exp_t e;
    int unsigned mx = lane ? 3 : 65535;
    int unsigned n  = (b > mx) ? mx : b;
    e.p    = (a * n) & 32'hffff;
    e.it   = n;
    e.er   = (b > mx);
    e.dcyc = cyc + 64'(sa + sb + 3 + 2 * n);
    e.lp0  = lane ? lp_tot1 : lp_tot0;
    if (lane) q1.push_back(e);
    else q0.push_back(e);
    repeat (sa) begin op_valid = 1'b0; bus = 8'($urandom); @(posedge clk); #1; end
    op_valid = 1'b1; bus = 8'(a); @(posedge clk); #1;
    repeat (sb) begin op_valid = 1'b0; bus = 8'($urandom); @(posedge clk); #1; end
    op_valid = 1'b1; bus = 8'(b); @(posedge clk); #1;
    op_valid = 1'b0; bus = 8'($urandom);
  endtask

  task automatic issue(input bit lane, input int unsigned a, input int unsigned b,
                       input int unsigned sa, input int unsigned sb, input bit hold);
    @(posedge clk); #1;
    if (lane) start_s = 1'b1;
    else start = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin start = 1'b0; start_s = 1'b0; end
    feed(lane, a, b, sa, sb);
  endtask

  task automatic wait_done(input bit lane);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if ((lane ? q1.size() : q0.size()) == 0) begin ok = 1'b1; break; end
    end
    chk(lane ? "done_timeout1" : "done_timeout0", 64'(ok), 64'd1);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    #3;
    chk("reset_outs0", 64'({ld_a0, ld_b0, clr_p0, ld_p0, dec_b0, busy0, done0, err0}), 64'd0);
    chk("reset_iter0", 64'(it0), 64'd0);
    chk("reset_outs1", 64'({ld_a1, ld_b1, clr_p1, ld_p1, dec_b1, busy1, done1, err1}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(0, 7, 3, 0, 0, 0); wait_done(0);
    issue(0, 9, 0, 0, 0, 0); wait_done(0);
    issue(0, 5, 4, 2, 1, 0); wait_done(0);
    issue(1, 6, 5, 0, 0, 0); wait_done(1);

    // Asynchronous reset in the middle of the add loop: outputs drop at once, no done.
    issue(0, 3, 3, 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ld_p0) begin found = 1'b1; break; end
    end
    chk("reached_add", 64'(found), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_outs0", 64'({ld_a0, ld_b0, clr_p0, ld_p0, dec_b0, busy0, done0, err0}), 64'd0);
    chk("abort_iter0", 64'(it0), 64'd0);
    q0.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    issue(0, 4, 2, 0, 0, 0); wait_done(0);

    // start held high: one operation, the next begins from IDLE right after DONE.
    issue(0, 5, 2, 0, 0, 1); wait_done(0);
    @(posedge clk); #1;
    chk("idle_after_done", 64'(busy0), 64'd0);
    @(posedge clk); #1;
    chk("restart_busy", 64'(busy0), 64'd1);
    start = 1'b0;
    feed(0, 6, 1, 0, 0);
    wait_done(0);

    for (int k = 0; k < 10; k++) begin
      bit lane;
      int unsigned a, b, sa, sb;
      lane = 1'($urandom_range(0, 1));
      a    = $urandom_range(0, 255);
      b    = lane ? $urandom_range(0, 6) : $urandom_range(0, 15);
      sa   = $urandom_range(0, 2);
      sb   = $urandom_range(0, 2);
      issue(lane, a, b, sa, sb, 0);
      wait_done(lane);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
